fpmul_rr_sched: RTL and testbench
=================================

Name: fpmul_rr_sched

Overview:
Round-robin scheduler that shares one combinational double-precision FPMul datapath (N1, N2 -> out) among NUM_REQ requesters.
- Accepts one operand pair at a time over valid/ready handshakes.
- Registers the operands and holds them stable for MUL_CYCLES cycles, so FPMul runs as a multicycle path.
- Captures the product and returns it, tagged with the requester id, over a backpressured response port.
- Sits between the FPU issue logic and the FPMul instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
ID_W, 2, requester id width; must satisfy 2**ID_W >= NUM_REQ.
MUL_CYCLES, 2, cycles the operands are held before the product is captured (1..15).

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  synchronous active-low reset.
req_valid  in  NUM_REQ  per-requester request valid.
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
req_a  in  NUM_REQ*64  flattened IEEE-754 double operand A; slot i is [64*i+63:64*i].
req_b  in  NUM_REQ*64  flattened operand B, same slicing.
resp_valid  out  1  result valid.
resp_ready  in  1  consumer accept.
resp_data  out  64  FPMul product.
resp_id  out  ID_W  index of the requester the result belongs to.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at a clock edge), including mid-operation:
  - state=IDLE, resp_valid=0, resp_data=0, resp_id=0, busy=0.
  - Operand registers cleared; cycle counter=0.
  - RR pointer=NUM_REQ-1, so requester 0 has top priority next.
  - Any in-flight operation is discarded with no response.
- Arbitration (combinational, evaluated only in IDLE):
  - Grant the first asserted req_valid searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - req_ready = grant when state==IDLE, else all zero.
- Handshake rules:
  - A request is accepted on a cycle where req_valid[i]&&req_ready[i].
  - Requesters must hold valid and operands until accepted.
  - Dropping valid before acceptance is legal and has no effect.
- FSM IDLE:
  - On acceptance: latch req_a/req_b slot into op_a/op_b, latch id, set pointer=id, counter=MUL_CYCLES-1.
  - Go to CALC.
  - With no valid request, stay in IDLE.
- FSM CALC:
  - op_a/op_b drive FPMul N1/N2 continuously.
  - If counter==0: capture FPMul out into resp_data, copy id to resp_id, set resp_valid=1, go to RESP.
  - Otherwise decrement counter.
- FSM RESP:
  - resp_valid=1; resp_data and resp_id held stable.
  - On resp_ready: clear resp_valid and go to IDLE.
  - A new request can therefore be accepted on the cycle after the response handshake, not the same cycle.
- Latency: request accepted at edge T -> resp_valid high after edge T+MUL_CYCLES.
  - Example: MUL_CYCLES=2 gives the result visible in cycle T+2.
  - Minimum issue interval = MUL_CYCLES+2 cycles with resp_ready tied high.
- Fairness: a continuously requesting port waits at most NUM_REQ-1 grants.
- Simultaneous events:
  - Requests arriving while busy are not acknowledged; they stay pending.
  - resp_ready while resp_valid=0 is ignored.
- Arithmetic: products pass through unmodified (sign, zero, rounding all from FPMul); the scheduler does no FP logic.
- No operand or result bits may change between acceptance and the response handshake.

Decomposition:
- Shared header fpu_defs.vh: state encoding (IDLE=2'd0, CALC=2'd1, RESP=2'd2), DW=64, and the FP constants used by benches (FP_ONE, FP_TWO, ...).
- Sub-module rr_arbiter (NUM_REQ; inputs req, ptr; output one-hot grant plus encoded index): pure combinational, reused by other FPU schedulers.
- fpmul_rr_sched instantiates rr_arbiter and the existing FPMul.

Test Plan:
1. Single request, MUL_CYCLES=2, resp_ready=1:
   - Req0: a=0x4000000000000000 (2.0), b=0x4008000000000000 (3.0).
   - Expect resp_data=0x4018000000000000, resp_id=0, resp_valid exactly 2 cycles after acceptance, busy high throughout.
2. All four requesters valid from reset, each with a distinct product:
   - Req0: 1.0*1.0 -> 0x3FF0000000000000.
   - Req1: 1.5*-5.0 -> 0xC01E000000000000.
   - Req2: -5.0*-5.0 -> 0x4039000000000000.
   - Req3: 0.0*123.0 -> 0x0000000000000000.
   - Grants in order 0,1,2,3, then wrap to 0; ids and data match.
3. Backpressure: hold resp_ready=0 for 5 cycles in RESP.
   - resp_data/resp_id stay stable, req_ready stays 0.
   - Release -> one handshake, then IDLE.
4. Fairness: req0 and req2 permanently valid.
   - Grants alternate 0,2,0,2; req1 asserted later is served before req2 when the pointer=0.
5. Reset mid-CALC (rst_n=0 one cycle):
   - Next cycle state IDLE, resp_valid=0, busy=0.
   - No response emitted for the aborted op; the next grant goes to requester 0.
6. Requester drops valid before being granted while the block is busy:
   - No acceptance, no response for it.
   - Pointer unaffected.

Source files
------------

// File: rtl/fpmul_rr_sched_pkg.sv
// rtl/fpmul_rr_sched_pkg.sv - shared FSM encoding, data width and FP constants for the FPU schedulers
package fpmul_rr_sched_pkg;

  localparam int DW = 64;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [63:0] FP_ZERO     = 64'h0000000000000000;
  localparam logic [63:0] FP_ONE      = 64'h3FF0000000000000;
  localparam logic [63:0] FP_ONE_HALF = 64'h3FF8000000000000;
  localparam logic [63:0] FP_TWO      = 64'h4000000000000000;
  localparam logic [63:0] FP_THREE    = 64'h4008000000000000;
  localparam logic [63:0] FP_NEG_FIVE = 64'hC014000000000000;
  localparam logic [63:0] FP_123      = 64'h405EC00000000000;

endpackage

// File: rtl/FPMul.sv
// rtl/FPMul.sv - combinational IEEE-754 double multiplier, round-to-nearest-even
module FPMul (
  input  logic [63:0] N1,
  input  logic [63:0] N2,
  output logic [63:0] out
);

  logic         w_sign;
  logic [10:0]  w_ea;
  logic [10:0]  w_eb;
  logic         w_a_zero;
  logic         w_b_zero;
  logic         w_a_inf;
  logic         w_b_inf;
  logic         w_a_nan;
  logic         w_b_nan;
  logic [105:0] w_prod;
  logic         w_norm;
  logic [52:0]  w_mant;
  logic         w_guard;
  logic         w_sticky;
  logic         w_rnd;
  logic [53:0]  w_mant_r;
  logic [51:0]  w_frac;
  logic [12:0]  w_exp;
  logic [12:0]  w_exp_b;
  logic         w_ovf;
  logic         w_unf;

  assign w_sign   = N1[63] ^ N2[63];
  assign w_ea     = N1[62:52];
  assign w_eb     = N2[62:52];
  // Subnormal inputs are treated as zero and underflowing results flush to zero.
  assign w_a_zero = (w_ea == 11'd0);
  assign w_b_zero = (w_eb == 11'd0);
  assign w_a_inf  = (w_ea == 11'h7FF) && (N1[51:0] == 52'd0);
  assign w_b_inf  = (w_eb == 11'h7FF) && (N2[51:0] == 52'd0);
  assign w_a_nan  = (w_ea == 11'h7FF) && (N1[51:0] != 52'd0);
  assign w_b_nan  = (w_eb == 11'h7FF) && (N2[51:0] != 52'd0);

  assign w_prod   = {53'd0, 1'b1, N1[51:0]} * {53'd0, 1'b1, N2[51:0]};
  assign w_norm   = w_prod[105];
  assign w_mant   = w_norm ? w_prod[105:53] : w_prod[104:52];
  assign w_guard  = w_norm ? w_prod[52] : w_prod[51];
  assign w_sticky = w_norm ? (|w_prod[51:0]) : (|w_prod[50:0]);
  assign w_rnd    = w_guard & (w_sticky | w_mant[0]);
  assign w_mant_r = {1'b0, w_mant} + {53'd0, w_rnd};
  assign w_frac   = w_mant_r[53] ? w_mant_r[52:1] : w_mant_r[51:0];

  assign w_exp    = {2'b00, w_ea} + {2'b00, w_eb} + {12'd0, w_norm} + {12'd0, w_mant_r[53]};
  assign w_exp_b  = w_exp - 13'd1023;
  assign w_unf    = w_exp_b[12] || (w_exp_b == 13'd0);
  assign w_ovf    = !w_exp_b[12] && (w_exp_b[11:0] >= 12'd2047);

  always_comb begin
    out = {w_sign, w_exp_b[10:0], w_frac};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      out = 64'h7FF8000000000000;
    end else if (w_a_inf || w_b_inf || (!w_a_zero && !w_b_zero && w_ovf)) begin
      out = {w_sign, 11'h7FF, 52'd0};
    end else if (w_a_zero || w_b_zero || w_unf) begin
      out = {w_sign, 63'd0};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts just above ptr and wraps
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  int w_best;
  int w_dist;

  // Rank each requester by its distance from ptr+1; the nearest asserted one wins.
  always_comb begin
    w_best = NUM_REQ;
    w_dist = 0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + 2 * NUM_REQ - int'(ptr) - 1) % NUM_REQ;
      if (req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        idx    = IDX_W'(i);
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = (w_best < NUM_REQ) && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/fpmul_rr_sched.sv
// rtl/fpmul_rr_sched.sv - round-robin scheduler sharing one multicycle FPMul datapath
module fpmul_rr_sched
  import fpmul_rr_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int MUL_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*DW-1:0] req_a,
  input  logic [NUM_REQ*DW-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DW-1:0]         resp_data,
  output logic [ID_W-1:0]       resp_id,
  output logic                  busy
);

  localparam int CNT_W = 4;

  logic [1:0]         r_state;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_id;
  logic [DW-1:0]      r_op_a;
  logic [DW-1:0]      r_op_b;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_resp_valid;
  logic [DW-1:0]      r_resp_data;
  logic [ID_W-1:0]    r_resp_id;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_idx;
  logic [DW-1:0]      w_sel_a;
  logic [DW-1:0]      w_sel_b;
  logic [DW-1:0]      w_prod;
  logic               w_idle;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_idx)
  );

  // Operands stay registered for the whole CALC window, so FPMul is a multicycle path.
  FPMul u_fpmul (
    .N1  (r_op_a),
    .N2  (r_op_b),
    .out (w_prod)
  );

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a = req_a[DW*i +: DW];
        w_sel_b = req_b[DW*i +: DW];
      end
    end
  end

  assign w_idle     = (r_state == ST_IDLE);
  assign req_ready  = w_idle ? w_grant : '0;
  assign busy       = !w_idle;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_id    = r_resp_id;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ptr        <= ID_W'(NUM_REQ - 1);
      r_id         <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_id    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_grant) begin
            r_op_a  <= w_sel_a;
            r_op_b  <= w_sel_b;
            r_id    <= w_idx;
            r_ptr   <= w_idx;
            r_cnt   <= CNT_W'(MUL_CYCLES - 1);
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (r_cnt == '0) begin
            r_resp_data  <= w_prod;
            r_resp_id    <= r_id;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmul_rr_sched.sv
// tb/tb_fpmul_rr_sched.sv - directed and random bench for fpmul_rr_sched against a real-arithmetic model
module tb_fpmul_rr_sched;
  import fpmul_rr_sched_pkg::*;

  localparam int NUM_REQ    = 4;
  localparam int ID_W       = 2;
  localparam int MUL_CYCLES = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*64-1:0] req_a;
  logic [NUM_REQ*64-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [63:0]           resp_data;
  logic [ID_W-1:0]       resp_id;
  logic                  busy;

  logic [63:0] a_op [NUM_REQ];
  logic [63:0] b_op [NUM_REQ];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_ptr   = NUM_REQ - 1;
  logic [63:0] last_data;

  fpmul_rr_sched #(
    .NUM_REQ    (NUM_REQ),
    .ID_W       (ID_W),
    .MUL_CYCLES (MUL_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[64*i +: 64] = a_op[i];
      req_b[64*i +: 64] = b_op[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mul_ref(input logic [63:0] x, input logic [63:0] y);
    return $realtobits($bitstoreal(x) * $bitstoreal(y));
  endfunction

  // Normal doubles with exponents near 1.0 so products never overflow or go subnormal.
  function automatic logic [63:0] rand_fp();
    logic [63:0] r;
    r[63]    = 1'($urandom_range(0, 1));
    r[62:52] = 11'($urandom_range(823, 1223));
    r[51:20] = $urandom;
    r[19:0]  = 20'($urandom);
    return r;
  endfunction

  function automatic int exp_grant(input logic [NUM_REQ-1:0] v, input int p);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (p + k) % NUM_REQ;
      if (v[ID_W'(c)]) return c;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_ptr = NUM_REQ - 1;
  endtask

  // One full transaction: arbitration, latency, optional backpressure, handshake.
  task automatic serve(input string tag, input bit keep, input int bp, input logic [NUM_REQ-1:0] drop);
    int              g;
    int              waited;
    logic [ID_W-1:0] gi;
    logic [63:0]     exp_d;
    waited     = 0;
    resp_ready = (bp == 0);
    #1;
    while (req_ready == '0 && waited < 20) begin
      tick();
      #1;
      waited++;
    end
    g = exp_grant(req_valid, m_ptr);
    check({tag, ":grant"}, 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    if (g < 0) return;
    gi    = ID_W'(g);
    exp_d = mul_ref(a_op[gi], b_op[gi]);
    m_ptr = g;
    tick();
    if (!keep) req_valid[gi] = 1'b0;
    req_valid = req_valid & ~drop;
    a_op[gi]  = rand_fp();
    b_op[gi]  = rand_fp();
    for (int k = 1; k < MUL_CYCLES; k++) begin
      tick();
      check({tag, ":calc_busy"}, 64'(busy), 64'd1);
      check({tag, ":calc_no_resp"}, 64'(resp_valid), 64'd0);
    end
    tick();
    check({tag, ":resp_valid"}, 64'(resp_valid), 64'd1);
    check({tag, ":resp_data"}, resp_data, exp_d);
    check({tag, ":resp_id"}, 64'(resp_id), 64'(g));
    check({tag, ":resp_busy"}, 64'(busy), 64'd1);
    last_data = resp_data;
    for (int j = 0; j < bp; j++) begin
      tick();
      check({tag, ":bp_valid"}, 64'(resp_valid), 64'd1);
      check({tag, ":bp_data"}, resp_data, exp_d);
      check({tag, ":bp_id"}, 64'(resp_id), 64'(g));
      check({tag, ":bp_ready"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    tick();
    check({tag, ":done_valid"}, 64'(resp_valid), 64'd0);
    check({tag, ":done_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int seen;
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_op[i] = rand_fp();
      b_op[i] = rand_fp();
    end
    tick();
    do_reset();
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_resp_id", 64'(resp_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);

    a_op[0]   = FP_TWO;
    b_op[0]   = FP_THREE;
    req_valid = 4'b0001;
    serve("t1", 1'b0, 0, '0);
    check("t1_product", last_data, 64'h4018000000000000);

    a_op[0] = FP_ONE;      b_op[0] = FP_ONE;
    a_op[1] = FP_ONE_HALF; b_op[1] = FP_NEG_FIVE;
    a_op[2] = FP_NEG_FIVE; b_op[2] = FP_NEG_FIVE;
    a_op[3] = FP_ZERO;     b_op[3] = FP_123;
    req_valid = 4'b1111;
    do_reset();
    serve("t2_r0", 1'b1, 0, '0);
    check("t2_p0", last_data, 64'h3FF0000000000000);
    serve("t2_r1", 1'b1, 0, '0);
    check("t2_p1", last_data, 64'hC01E000000000000);
    serve("t2_r2", 1'b1, 0, '0);
    check("t2_p2", last_data, 64'h4039000000000000);
    serve("t2_r3", 1'b1, 0, '0);
    check("t2_p3", last_data, 64'h0000000000000000);
    serve("t2_wrap", 1'b1, 0, '0);
    req_valid = '0;

    req_valid = 4'b0010;
    serve("t3_bp", 1'b0, 5, '0);

    do_reset();
    req_valid = 4'b0101;
    serve("t4_a", 1'b1, 0, '0);
    serve("t4_b", 1'b1, 0, '0);
    serve("t4_c", 1'b1, 0, '0);
    req_valid[1] = 1'b1;
    serve("t4_late", 1'b0, 0, '0);
    serve("t4_d", 1'b1, 0, '0);
    req_valid = '0;

    req_valid = 4'b1000;
    #1;
    check("t5_grant", 64'(req_ready), 64'(4'b1000));
    tick();
    req_valid = '0;
    tick();
    check("t5_in_calc", 64'(busy), 64'd1);
    do_reset();
    check("t5_rst_valid", 64'(resp_valid), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_data", resp_data, 64'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (resp_valid) seen++;
    end
    check("t5_no_resp", 64'(seen), 64'd0);
    req_valid = 4'b1001;
    serve("t5_next", 1'b0, 0, '0);
    req_valid = '0;

    req_valid = 4'b1010;
    serve("t6_busy", 1'b0, 0, 4'b1000);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy || req_ready != '0 || resp_valid) seen++;
    end
    check("t6_no_accept", 64'(seen), 64'd0);
    req_valid = 4'b0101;
    serve("t6_ptr", 1'b0, 0, '0);
    req_valid = '0;

    for (int it = 0; it < 25; it++) begin
      req_valid = req_valid | NUM_REQ'($urandom_range(1, 15));
      serve("rand", 1'b0, $urandom_range(0, 2), '0);
    end
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
